// File: rtl/flex_sr_pkg.sv
// Shared definitions for the flexible serial-to-parallel word shift register.
package flex_sr_pkg;

  localparam logic SHIFT_TO_MSB = 1'b1;
  localparam logic SHIFT_TO_LSB = 1'b0;

  // Counter width for a word of n bits, never narrower than one bit.
  function automatic int cnt_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/stp_bit_counter.sv
// Bit-position counter for one word; flags the bit that completes the word.
module stp_bit_counter
  import flex_sr_pkg::*;
#(
  parameter int NUM_BITS = 8,
  localparam int CNT_W   = cnt_w(NUM_BITS)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             count_enable,
  output logic [CNT_W-1:0] count,
  output logic             rollover
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             last_bit;

  assign last_bit = (count_q == CNT_W'(NUM_BITS - 1));
  assign rollover = count_enable & last_bit;
  assign count    = count_q;

  always_comb begin
    count_d = count_q;
    if (clear)
      count_d = '0;
    else if (count_enable)
      count_d = last_bit ? '0 : count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/flex_stp_word_sr.sv
// Serial-to-parallel shift register with word capture, valid/ack handshake
// and a sticky overrun flag for words replaced before acknowledgement.
module flex_stp_word_sr
  import flex_sr_pkg::*;
#(
  parameter int                    NUM_BITS    = 8,
  parameter logic                  SHIFT_MSB   = 1'b1,
  parameter logic [NUM_BITS-1:0]   RESET_VALUE = NUM_BITS'(1),
  localparam int                   CNT_W       = cnt_w(NUM_BITS)
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                shift_enable,
  input  logic                serial_in,
  input  logic                clear,
  input  logic                word_ack,
  output logic [NUM_BITS-1:0] parallel_out,
  output logic [NUM_BITS-1:0] word_out,
  output logic                word_valid,
  output logic                overrun,
  output logic [CNT_W-1:0]    bit_count
);

  logic [NUM_BITS-1:0] shift_q, shift_d, shift_nxt;
  logic [NUM_BITS-1:0] word_q, word_d;
  logic                valid_q, valid_d;
  logic                ovr_q, ovr_d;
  logic                rollover;

  stp_bit_counter #(.NUM_BITS(NUM_BITS)) u_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .count_enable (shift_enable),
    .count        (bit_count),
    .rollover     (rollover)
  );

  always_comb begin
    if (SHIFT_MSB == SHIFT_TO_MSB)
      shift_nxt = {shift_q[NUM_BITS-2:0], serial_in};
    else
      shift_nxt = {serial_in, shift_q[NUM_BITS-1:1]};
  end

  // Clear wins over shift and ack; a completing bit wins over a plain ack.
  always_comb begin
    shift_d = shift_q;
    word_d  = word_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (clear) begin
      shift_d = RESET_VALUE;
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end else begin
      if (shift_enable)
        shift_d = shift_nxt;
      if (rollover) begin
        word_d  = shift_nxt;
        valid_d = 1'b1;
        if (valid_q && !word_ack)
          ovr_d = 1'b1;
      end else if (word_ack && valid_q) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      shift_q <= RESET_VALUE;
      word_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign parallel_out = shift_q;
  assign word_out     = word_q;
  assign word_valid   = valid_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_flex_stp_word_sr.sv
// Directed bench for flex_stp_word_sr: one MSB-shifting and one LSB-shifting instance.
module tb_flex_stp_word_sr;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       shift_enable, serial_in, clear, word_ack;
  logic [7:0] m_par, m_word, l_par, l_word;
  logic       m_valid, m_ovr, l_valid, l_ovr;
  logic [2:0] m_cnt, l_cnt;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  flex_stp_word_sr #(.NUM_BITS(8), .SHIFT_MSB(1'b1)) dut_msb (
    .clk(clk), .n_rst(n_rst), .shift_enable(shift_enable), .serial_in(serial_in),
    .clear(clear), .word_ack(word_ack), .parallel_out(m_par), .word_out(m_word),
    .word_valid(m_valid), .overrun(m_ovr), .bit_count(m_cnt)
  );

  flex_stp_word_sr #(.NUM_BITS(8), .SHIFT_MSB(1'b0)) dut_lsb (
    .clk(clk), .n_rst(n_rst), .shift_enable(shift_enable), .serial_in(serial_in),
    .clear(clear), .word_ack(word_ack), .parallel_out(l_par), .word_out(l_word),
    .word_valid(l_valid), .overrun(l_ovr), .bit_count(l_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    n_rst = 1'b0; shift_enable = 1'b0; serial_in = 1'b0; clear = 1'b0; word_ack = 1'b0;
    tick();
    n_rst = 1'b1;
    tick();
  endtask

  // Shift bits[7] first .. bits[0] last; optionally hold ack on the completing bit.
  task automatic send_seq(input logic [7:0] bits, input logic ack_last);
    for (int i = 7; i >= 0; i--) begin
      shift_enable = 1'b1;
      serial_in    = bits[i];
      word_ack     = ack_last && (i == 0);
      tick();
    end
    shift_enable = 1'b0;
    word_ack     = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      shift_enable = 1'b1; serial_in = 1'b1; tick();
    end
    shift_enable = 1'b0;
    total++; if (m_cnt !== 3'd3) begin bad++; $display("FAIL pre_reset_count got=%0d want=3", m_cnt); end
    #3 n_rst = 1'b0;
    #1;
    total++; if (m_par !== 8'h01) begin bad++; $display("FAIL reset_par got=%h want=01", m_par); end
    total++; if (m_word !== 8'h00) begin bad++; $display("FAIL reset_word got=%h want=00", m_word); end
    total++; if (m_valid !== 1'b0 || m_ovr !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b want=00", m_valid, m_ovr); end
    total++; if (m_cnt !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", m_cnt); end
    total++; if (l_par !== 8'h01) begin bad++; $display("FAIL reset_par_lsb got=%h want=01", l_par); end
    tick();
    n_rst = 1'b1;
    tick();
  endtask

  task automatic test_msb_mode();
    do_reset();
    shift_enable = 1'b1; serial_in = 1'b1; tick(); shift_enable = 1'b0;
    total++; if (m_par !== 8'h03) begin bad++; $display("FAIL msb_first_bit got=%h want=03", m_par); end
    total++; if (m_cnt !== 3'd1) begin bad++; $display("FAIL msb_count1 got=%0d want=1", m_cnt); end
    do_reset();
    send_seq(8'hA5, 1'b0);
    total++; if (m_word !== 8'hA5) begin bad++; $display("FAIL msb_word got=%h want=a5", m_word); end
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL msb_valid got=%b want=1", m_valid); end
    total++; if (m_cnt !== 3'd0) begin bad++; $display("FAIL msb_count_wrap got=%0d want=0", m_cnt); end
    total++; if (m_par !== 8'hA5) begin bad++; $display("FAIL msb_par got=%h want=a5", m_par); end
    word_ack = 1'b1; tick(); word_ack = 1'b0;
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL msb_ack got=%b want=0", m_valid); end
    word_ack = 1'b1; tick(); word_ack = 1'b0;
    total++; if (m_valid !== 1'b0 || m_ovr !== 1'b0 || m_word !== 8'hA5) begin
      bad++; $display("FAIL msb_idle_ack got=%b%b/%h want=00/a5", m_valid, m_ovr, m_word);
    end
  endtask

  task automatic test_lsb_mode();
    do_reset();
    shift_enable = 1'b1; serial_in = 1'b1; tick(); shift_enable = 1'b0;
    total++; if (l_par !== 8'h80) begin bad++; $display("FAIL lsb_first_bit got=%h want=80", l_par); end
    do_reset();
    // A5 sent LSB-first: bit0..bit7 = 1,0,1,0,0,1,0,1
    send_seq(8'b1010_0101, 1'b0);
    total++; if (l_word !== 8'hA5) begin bad++; $display("FAIL lsb_word got=%h want=a5", l_word); end
    total++; if (l_valid !== 1'b1 || l_cnt !== 3'd0) begin bad++; $display("FAIL lsb_valid_cnt got=%b/%0d want=1/0", l_valid, l_cnt); end
    do_reset();
    // 8'h96 LSB-first is 0,1,1,0,1,0,0,1
    send_seq(8'b0110_1001, 1'b0);
    total++; if (l_word !== 8'h96) begin bad++; $display("FAIL lsb_word2 got=%h want=96", l_word); end
    total++; if (m_word !== 8'h69) begin bad++; $display("FAIL msb_word2 got=%h want=69", m_word); end
  endtask

  task automatic test_overrun();
    do_reset();
    send_seq(8'h3C, 1'b0);
    total++; if (m_valid !== 1'b1 || m_ovr !== 1'b0) begin bad++; $display("FAIL ovr_first got=%b%b want=10", m_valid, m_ovr); end
    send_seq(8'hC3, 1'b0);
    total++; if (m_word !== 8'hC3) begin bad++; $display("FAIL ovr_word got=%h want=c3", m_word); end
    total++; if (m_valid !== 1'b1 || m_ovr !== 1'b1) begin bad++; $display("FAIL ovr_flags got=%b%b want=11", m_valid, m_ovr); end
    word_ack = 1'b1; tick(); word_ack = 1'b0;
    total++; if (m_valid !== 1'b0 || m_ovr !== 1'b1) begin bad++; $display("FAIL ovr_after_ack got=%b%b want=01", m_valid, m_ovr); end
    tick();
    total++; if (m_ovr !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b want=1", m_ovr); end
    clear = 1'b1; tick(); clear = 1'b0;
    total++; if (m_ovr !== 1'b0 || m_word !== 8'hC3 || m_par !== 8'h01) begin
      bad++; $display("FAIL ovr_clear got=%b/%h/%h want=0/c3/01", m_ovr, m_word, m_par);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_seq(8'h3C, 1'b0);
    send_seq(8'hA5, 1'b1);
    total++; if (m_valid !== 1'b1 || m_word !== 8'hA5) begin bad++; $display("FAIL simul_word got=%b/%h want=1/a5", m_valid, m_word); end
    total++; if (m_ovr !== 1'b0) begin bad++; $display("FAIL simul_ovr got=%b want=0", m_ovr); end
  endtask

  task automatic test_clear_midword();
    do_reset();
    send_seq(8'hA5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      shift_enable = 1'b1; serial_in = (i != 2); tick();
    end
    total++; if (m_cnt !== 3'd3 || m_par !== 8'h2E) begin bad++; $display("FAIL clr_partial got=%0d/%h want=3/2e", m_cnt, m_par); end
    clear = 1'b1; shift_enable = 1'b1; serial_in = 1'b1; word_ack = 1'b0; tick();
    clear = 1'b0; shift_enable = 1'b0;
    total++; if (m_cnt !== 3'd0 || m_par !== 8'h01) begin bad++; $display("FAIL clr_state got=%0d/%h want=0/01", m_cnt, m_par); end
    total++; if (m_valid !== 1'b0 || m_word !== 8'hA5) begin bad++; $display("FAIL clr_word got=%b/%h want=0/a5", m_valid, m_word); end
    send_seq(8'h3C, 1'b0);
    total++; if (m_valid !== 1'b1 || m_word !== 8'h3C || m_ovr !== 1'b0) begin
      bad++; $display("FAIL clr_next_word got=%b/%h/%b want=1/3c/0", m_valid, m_word, m_ovr);
    end
  endtask

  initial begin
    test_reset();
    test_msb_mode();
    test_lsb_mode();
    test_overrun();
    test_back_to_back();
    test_clear_midword();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
